// File: rtl/seq_branch_compare.sv
// rtl/seq_branch_compare.sv - multi-cycle MSB-first slice comparator for branch/SLT resolution
module seq_branch_compare #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            result,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);
    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state;
    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic [2:0]        op_r;
    logic [IW-1:0]     idx;

    logic [CHUNK-1:0]  a_slice;
    logic [CHUNK-1:0]  b_slice;
    logic              slice_diff;
    logic              n_eq;
    logic              n_ltu;
    logic              n_lt;

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                a_slice = a_r[i*CHUNK +: CHUNK];
                b_slice = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

    // Sign bits differing decide the signed order outright; otherwise it matches unsigned.
    always_comb begin
        slice_diff = (a_slice != b_slice);
        n_eq       = ~slice_diff;
        n_ltu      = slice_diff & (a_slice < b_slice);
        n_lt       = (a_r[XLEN-1] != b_r[XLEN-1]) ? a_r[XLEN-1] : n_ltu;
    end

    function automatic logic sel_result(input logic [2:0] f, input logic e,
                                        input logic l, input logic lu);
        case (f)
            3'b000:  sel_result = e;
            3'b001:  sel_result = ~e;
            3'b100:  sel_result = l;
            3'b101:  sel_result = ~l;
            3'b110:  sel_result = lu;
            3'b111:  sel_result = ~lu;
            default: sel_result = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            ltu       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        op_r     <= op;
                        idx      <= IW'(NCHUNK - 1);
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (slice_diff || idx == '0) begin
                        eq        <= n_eq;
                        ltu       <= n_ltu;
                        lt        <= n_lt;
                        result    <= sel_result(op_r, n_eq, n_lt, n_ltu);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_branch_compare.sv
// tb/tb_seq_branch_compare.sv - directed self-checking bench for seq_branch_compare
module tb_seq_branch_compare;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic        result;
    logic        eq;
    logic        lt;
    logic        ltu;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    seq_branch_compare #(.XLEN(64), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .eq        (eq),
        .lt        (lt),
        .ltu       (ltu)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [63:0] va, input logic [63:0] vb, input logic [2:0] vop);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        a = va; b = vb; op = vop; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~va; b = ~vb; op = ~vop;
        chk("accept_in_ready_low", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic flags(input string tag, input logic e, input logic l,
                         input logic lu, input logic r);
        chk({tag, "_eq"},  64'(eq),     64'(e));
        chk({tag, "_lt"},  64'(lt),     64'(l));
        chk({tag, "_ltu"}, 64'(ltu),    64'(lu));
        chk({tag, "_res"}, 64'(result), 64'(r));
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ack_out_valid", 64'(out_valid), 64'd0);
        chk("ack_in_ready",  64'(in_ready),  64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Reset mid-scan: no result may ever appear
        send(64'd0, 64'd1, 3'b110);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_result", 64'(out_valid), 64'd0);
        end

        // Early exit on the top slice
        send(64'h8000_0000_0000_0000, 64'd0, 3'b110);
        wait_out("top_lat", 1);
        flags("top_ltu", 1'b0, 1'b1, 1'b0, 1'b0);
        ack();
        send(64'h8000_0000_0000_0000, 64'd0, 3'b100);
        wait_out("top_lat2", 1);
        flags("top_lt", 1'b0, 1'b1, 1'b0, 1'b1);
        ack();

        // Full scan, bottom slice differs
        send(64'd5, 64'd7, 3'b110);
        wait_out("bot_lat", 8);
        flags("bot_ltu", 1'b0, 1'b1, 1'b1, 1'b1);
        ack();
        send(64'd5, 64'd7, 3'b111);
        wait_out("bot_lat2", 8);
        flags("bot_geu", 1'b0, 1'b1, 1'b1, 1'b0);
        ack();

        // Equal operands
        send(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 3'b000);
        wait_out("eq_lat", 8);
        flags("eq_eq", 1'b1, 1'b0, 1'b0, 1'b1);
        ack();
        send(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 3'b001);
        wait_out("eq_lat2", 8);
        flags("eq_ne", 1'b1, 1'b0, 1'b0, 1'b0);
        ack();

        // Signed/unsigned split, plus reserved op
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b101);
        wait_out("split_lat", 1);
        flags("split_ge", 1'b0, 1'b1, 1'b0, 1'b0);
        ack();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111);
        wait_out("split_lat2", 1);
        flags("split_geu", 1'b0, 1'b1, 1'b0, 1'b1);
        ack();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b011);
        wait_out("rsv_lat", 1);
        flags("rsv", 1'b0, 1'b1, 1'b0, 1'b0);
        ack();

        // Backpressure in DONE
        send(64'd5, 64'd7, 3'b110);
        wait_out("bp_lat", 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        ack();

        // Back-to-back with in_valid held high
        send(64'd5, 64'd7, 3'b110);
        wait_out("b2b_lat1", 8);
        a = 64'h0000_0000_0000_0100; b = 64'd0; op = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_in_ready_held", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_ack_out_valid", 64'(out_valid), 64'd0);
        chk("b2b_ack_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_second_accept", 64'(in_ready), 64'd0);
        wait_out("b2b_lat2", 7);
        flags("b2b", 1'b0, 1'b0, 1'b0, 1'b0);
        ack();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/seq_branch_compare.md
Name: seq_branch_compare

Overview:
- Multi-cycle integer compare unit for the RISC-V core's branch and set-less-than paths.
- Scans the two operands from the MSB chunk downward, one CHUNK-bit slice per cycle, and stops early at the first differing slice.
- Produces equality, signed-less and unsigned-less flags, plus a funct3-selected branch/SLT result.
- Sits between the operand-read stage and branch resolution, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 64, operand width in bits.
- CHUNK, 8, bits examined per scan cycle. Must divide XLEN.
- NCHUNK, XLEN/CHUNK, derived count of slices. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- a  input  XLEN  operand rs1.
- b  input  XLEN  operand rs2.
- op  input  3  RISC-V branch funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  1  condition outcome selected by the captured op.
- eq  output  1  a == b.
- lt  output  1  a < b, signed.
- ltu  output  1  a < b, unsigned.

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - State goes to IDLE.
  - in_ready=1 after reset is released.
  - out_valid, result, eq, lt and ltu all clear to 0.
  - Captured operands and the slice index are discarded.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: register a, b and op, set idx=NCHUNK-1, go to SCAN.
- SCAN:
  - in_ready=0, out_valid=0.
  - Each cycle, compare slice a[idx*CHUNK +: CHUNK] against the same slice of b.
  - Slices differ: latch ltu = (a_slice < b_slice) unsigned, eq=0, go to DONE.
  - Slices equal and idx==0: latch eq=1, ltu=0, go to DONE.
  - Otherwise: idx decrements, stay in SCAN.
- Signed flag: lt = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : ltu. Computed from the registered operands, valid in DONE.
- result is selected by op:
  - EQ → eq; NE → ~eq.
  - LT → lt; GE → ~lt.
  - LTU → ltu; GEU → ~ltu.
  - Reserved op 010 or 011 → result=0; eq, lt and ltu are still correct.
- DONE:
  - out_valid=1.
  - result and flags are held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE. There is no accept in the same cycle, so in_ready rises the cycle after the result handshake.
- Latency:
  - Counted from the accepting clock edge to out_valid being visible: k cycles, where k is the number of slices examined (1..NCHUNK).
  - Equal operands always take NCHUNK cycles.
- Inputs a, b and op are ignored outside the IDLE handshake. Changes to them during SCAN or DONE have no effect.
- in_valid while busy is not consumed; the requester must hold it until in_ready.
- Throughput: one request in flight.

Test Plan:
- Reset mid-scan: a=0, b=1, op=110 accepted, rst_n pulsed low 2 cycles later → out_valid=0 and in_ready=0 immediately; after release in_ready=1 and no result appears.
- Early exit at the top slice: a=64'h8000_0000_0000_0000, b=0, op=110 → out_valid 1 cycle after accept; ltu=0, lt=1, eq=0, result=0. Repeat with op=100 → result=1.
- Full scan, bottom slice differs: a=5, b=7, op=110 → out_valid 8 cycles after accept; ltu=1, lt=1, result=1. Same operands with op=111 → result=0.
- Equal operands: a=b=64'hDEAD_BEEF_0123_4567, op=000 → 8-cycle latency; eq=1, lt=0, ltu=0, result=1. With op=001 → result=0.
- Signed/unsigned split: a=64'hFFFF_FFFF_FFFF_FFFF, b=1 → ltu=0, lt=1. op=101 → result=0; op=111 → result=1. Reserved op=011 → result=0 with flags unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and result stable, in_ready=0. Release out_ready → IDLE next cycle. Back-to-back requests with in_valid held high → second request accepted the cycle after the first result handshake.
